// File: rtl/l2_responder_pkg.sv
// ============================================================================
//  Module : l2_responder_pkg
//  Brief  : Shared cache widths and responder FSM encoding.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package l2_responder_pkg;

   localparam int c_LINE_W = 256;
   localparam int c_TAG_W  = 4;
   localparam int c_ADDR_W = 32;

   typedef logic [c_LINE_W-1:0] line_t;

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_BUSY = 2'd1;
   localparam logic [1:0] c_ST_RESP = 2'd2;

endpackage

`default_nettype wire

// File: rtl/l2_responder_req_fifo.sv
// ============================================================================
//  Module : req_fifo
//  Brief  : Power-of-two request queue with registered storage.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module req_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty
);

   localparam int            c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int            c_CW   = c_AW + 1;
   localparam logic [c_AW:0] c_FULL = c_CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_AW:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   // A full queue refuses the push even if a pop frees a slot this edge.
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;
   assign o_full    = (r_count == c_FULL);
   assign o_empty   = (r_count == '0);
   assign o_dout    = r_mem[r_rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_din;
   end

endmodule

`default_nettype wire

// File: rtl/l2_responder.sv
// ============================================================================
//  Module : l2_responder
//  Brief  : Fixed-latency in-order L2 line store answering L1 fills/writebacks.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module l2_responder
   import l2_responder_pkg::*;
#(
   parameter int LATENCY   = 8,
   parameter int QDEPTH    = 4,
   parameter int MEM_LINES = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [c_ADDR_W-1:0] addr_i,
   input  logic [c_LINE_W-1:0] data_i,
   input  logic                rw_i,
   input  logic                valid_i,
   input  logic [c_TAG_W-1:0]  id_i,
   output logic                stall_o,
   output logic [c_LINE_W-1:0] data_o,
   output logic                valid_o,
   output logic [c_TAG_W-1:0]  id_o
);

   localparam int         c_IDX_W = $clog2(MEM_LINES);
   localparam int         c_REQ_W = c_IDX_W + 1 + c_TAG_W + c_LINE_W;
   // BUSY spans LATENCY-1 cycles, so the counter starts two below LATENCY.
   localparam logic [7:0] c_LOAD  = 8'(LATENCY - 2);

   logic [c_REQ_W-1:0] w_push_req;
   logic [c_REQ_W-1:0] w_head;
   logic               w_full;
   logic               w_empty;
   logic               w_pop;
   logic               w_done;
   logic               w_wr_en;
   logic               w_unused_addr;

   logic [1:0]         r_state;
   logic [7:0]         r_cnt;
   logic [c_IDX_W-1:0] r_cur_idx;
   logic               r_cur_rw;
   logic [c_TAG_W-1:0] r_cur_id;
   line_t              r_cur_data;
   line_t              r_mem [MEM_LINES];

   assign w_push_req    = {addr_i[5 +: c_IDX_W], rw_i, id_i, data_i};
   assign w_unused_addr = ^{addr_i[c_ADDR_W-1:5+c_IDX_W], addr_i[4:0]};
   assign w_pop         = ((r_state == c_ST_IDLE) || (r_state == c_ST_RESP)) && !w_empty;
   assign w_done        = (r_state == c_ST_BUSY) && (r_cnt == 8'd0);
   assign w_wr_en       = w_done && r_cur_rw;
   assign stall_o       = w_full;

   req_fifo #(
      .DEPTH (QDEPTH),
      .WIDTH (c_REQ_W)
   ) u_req_fifo (
      .clk     (clk),
      .rst     (reset),
      .i_push  (valid_i),
      .i_pop   (w_pop),
      .i_din   (w_push_req),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= c_ST_IDLE;
         r_cnt      <= 8'd0;
         r_cur_idx  <= '0;
         r_cur_rw   <= 1'b0;
         r_cur_id   <= '0;
         r_cur_data <= '0;
         valid_o    <= 1'b0;
         data_o     <= '0;
         id_o       <= '0;
      end else begin
         valid_o <= 1'b0;
         if (w_pop) begin
            r_cur_idx  <= w_head[c_REQ_W-1 -: c_IDX_W];
            r_cur_rw   <= w_head[c_TAG_W+c_LINE_W];
            r_cur_id   <= w_head[c_LINE_W +: c_TAG_W];
            r_cur_data <= w_head[c_LINE_W-1:0];
         end
         case (r_state)
            c_ST_IDLE: begin
               if (w_pop) begin
                  r_cnt   <= c_LOAD;
                  r_state <= c_ST_BUSY;
               end
            end
            c_ST_BUSY: begin
               if (w_done) begin
                  r_state <= c_ST_RESP;
                  if (!r_cur_rw) begin
                     valid_o <= 1'b1;
                     data_o  <= r_mem[r_cur_idx];
                     id_o    <= r_cur_id;
                  end
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            c_ST_RESP: begin
               if (w_pop) begin
                  r_cnt   <= c_LOAD;
                  r_state <= c_ST_BUSY;
               end else begin
                  r_state <= c_ST_IDLE;
               end
            end
            default: r_state <= c_ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MEM_LINES; i++) r_mem[i] <= '0;
      end else if (w_wr_en) begin
         r_mem[r_cur_idx] <= r_cur_data;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_l2_responder.sv
// ============================================================================
//  Module : tb_l2_responder
//  Brief  : Scoreboard bench for l2_responder.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_l2_responder;

   localparam int LAT = 8;
   localparam int QD  = 4;
   localparam int ML  = 64;

   logic         clk   = 1'b0;
   logic         reset = 1'b0;
   logic [31:0]  addr_i;
   logic [255:0] data_i;
   logic         rw_i;
   logic         valid_i;
   logic [3:0]   id_i;
   logic         stall_o;
   logic [255:0] data_o;
   logic         valid_o;
   logic [3:0]   id_o;

   typedef struct {
      logic [3:0]   id;
      logic [255:0] data;
   } exp_t;

   exp_t         sb[$];
   int           resp_cyc[$];
   logic [255:0] model [ML];
   int           cyc = 0;
   int           n_cmp = 0;
   int           n_err = 0;

   l2_responder #(
      .LATENCY   (LAT),
      .QDEPTH    (QD),
      .MEM_LINES (ML)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .addr_i  (addr_i),
      .data_i  (data_i),
      .rw_i    (rw_i),
      .valid_i (valid_i),
      .id_i    (id_i),
      .stall_o (stall_o),
      .data_o  (data_o),
      .valid_o (valid_o),
      .id_o    (id_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Response monitor: every pulse must match the oldest outstanding read.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset && valid_o === 1'b1) begin
         n_cmp++;
         resp_cyc.push_back(cyc);
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_resp: valid_o with id %0d, required no response", id_o);
         end else begin
            e = sb.pop_front();
            if (id_o !== e.id || data_o !== e.data) begin
               n_err++;
               $display("FAIL resp_content: id %0d data %h, required id %0d data %h",
                        id_o, data_o, e.id, e.data);
            end
         end
      end
   end

   task automatic send(input logic rw, input logic [31:0] a, input logic [255:0] d,
                       input logic [3:0] id, output int acc);
      int   guard;
      exp_t e;
      @(negedge clk);
      valid_i = 1'b1; rw_i = rw; addr_i = a; data_i = d; id_i = id;
      guard = 0;
      while (stall_o === 1'b1 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) begin
         n_cmp++; n_err++;
         $display("FAIL stall_timeout: stall_o still %b after %0d cycles, required 0", stall_o, guard);
      end
      @(posedge clk); #1;
      acc     = cyc;
      valid_i = 1'b0;
      if (rw) model[a[10:5]] = d;
      else begin
         e.id   = id;
         e.data = model[a[10:5]];
         sb.push_back(e);
      end
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
      end
      repeat (LAT + 2) @(negedge clk);
   endtask

   task automatic test_reset();
      valid_i = 1'b0; rw_i = 1'b0; addr_i = '0; data_i = '0; id_i = '0;
      for (int i = 0; i < ML; i++) model[i] = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: %b, required 0", stall_o); end
      n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: %b, required 0", valid_o); end
      n_cmp++; if (data_o !== '0) begin n_err++; $display("FAIL reset_data: %h, required 0", data_o); end
      n_cmp++; if (id_o !== 4'd0) begin n_err++; $display("FAIL reset_id: %0d, required 0", id_o); end
      reset = 1'b0;
   endtask

   task automatic test_read_latency();
      int acc;
      resp_cyc.delete();
      send(1'b0, 32'd97, '0, 4'd2, acc);
      wait_drain();
      n_cmp++;
      if (resp_cyc.size() != 1 || resp_cyc[0] != acc + LAT) begin
         n_err++;
         $display("FAIL read_latency: %0d pulses first at edge %0d, required 1 at edge %0d",
                  resp_cyc.size(), (resp_cyc.size() > 0) ? resp_cyc[0] : -1, acc + LAT);
      end
   endtask

   task automatic test_raw();
      int           acc;
      logic [255:0] p;
      p = {{31{8'hA5}}, 8'h08};
      resp_cyc.delete();
      send(1'b1, 32'd97, p, 4'd6, acc);
      send(1'b0, 32'd101, '0, 4'd7, acc);
      wait_drain();
      n_cmp++;
      if (resp_cyc.size() != 1) begin
         n_err++; $display("FAIL raw_pulses: %0d pulses, required 1", resp_cyc.size());
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (id_o !== 4'd7 || data_o !== p) begin
         n_err++; $display("FAIL hold_outputs: id %0d data %h, required id 7 data %h", id_o, data_o, p);
      end
   endtask

   task automatic test_alias();
      int           acc;
      logic [255:0] q;
      q = {8{32'hC0DE_0006}};
      send(1'b1, 32'd197, q, 4'd1, acc);
      send(1'b0, 32'd65733, '0, 4'd3, acc);
      send(1'b0, 32'd197, '0, 4'd4, acc);
      wait_drain();
   endtask

   task automatic test_back_to_back();
      int acc0, acc[5];
      resp_cyc.delete();
      send(1'b0, 32'd160, '0, 4'd10, acc0);
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         send(1'b0, (i == 4) ? 32'd197 : 32'(i * 32 + 96), '0, 4'(11 + i), acc[i]);
         if (i < 4) begin
            n_cmp++;
            if (stall_o !== (i == 3)) begin
               n_err++; $display("FAIL stall_after_%0d: %b, required %b", i + 1, stall_o, (i == 3));
            end
         end
      end
      n_cmp++;
      if (acc[4] != acc0 + LAT + 2) begin
         n_err++; $display("FAIL fifth_accept: edge %0d, required %0d", acc[4], acc0 + LAT + 2);
      end
      wait_drain();
      n_cmp++;
      if (resp_cyc.size() != 6 || resp_cyc[0] != acc0 + LAT) begin
         n_err++; $display("FAIL b2b_count: %0d pulses, required 6 from edge %0d", resp_cyc.size(), acc0 + LAT);
      end else begin
         for (int i = 1; i < 6; i++) begin
            n_cmp++;
            if (resp_cyc[i] - resp_cyc[i-1] != LAT) begin
               n_err++; $display("FAIL b2b_spacing_%0d: %0d, required %0d", i, resp_cyc[i] - resp_cyc[i-1], LAT);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int acc;
      send(1'b0, 32'd97, '0, 4'd9, acc);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL mid_reset_valid: %b, required 0", valid_o); end
      n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL mid_reset_stall: %b, required 0", stall_o); end
      n_cmp++; if (data_o !== '0) begin n_err++; $display("FAIL mid_reset_data: %h, required 0", data_o); end
      sb.delete();
      for (int i = 0; i < ML; i++) model[i] = '0;
      @(negedge clk);
      reset = 1'b0;
      resp_cyc.delete();
      repeat (LAT + 4) @(negedge clk);
      n_cmp++;
      if (resp_cyc.size() != 0) begin
         n_err++; $display("FAIL mid_reset_discard: %0d pulses, required 0", resp_cyc.size());
      end
      send(1'b0, 32'd97, '0, 4'd11, acc);
      wait_drain();
      n_cmp++;
      if (resp_cyc.size() != 1 || resp_cyc[0] != acc + LAT) begin
         n_err++; $display("FAIL post_reset_read: %0d pulses, required 1 at edge %0d", resp_cyc.size(), acc + LAT);
      end
   endtask

   task automatic test_random();
      int acc;
      for (int i = 0; i < 16; i++) begin
         send(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7) * 32 + $urandom_range(0, 31)),
              {8{$urandom}}, 4'($urandom_range(0, 15)), acc);
      end
      wait_drain();
   endtask

   initial begin
      test_reset();
      test_read_latency();
      test_raw();
      test_alias();
      test_back_to_back();
      test_reset_mid();
      test_random();
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++; $display("FAIL final_outstanding: %0d, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/l2_responder.md
L2_RESPONDER -- requirements
Module: l2_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 8, cycles from request acceptance to response (legal range 2..255).
REQ-002 SHALL have parameter QDEPTH, default 4, request queue entries (power of two).
REQ-003 SHALL have parameter MEM_LINES, default 64, number of 256-bit lines held (power of two).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port addr_i, input, 32, byte address of the L1 miss/writeback line.
REQ-007 SHALL have port data_i, input, 256, writeback line data; ignored for reads.
REQ-008 SHALL have port rw_i, input, 1, 1 = write (writeback), 0 = read (line fill).
REQ-009 SHALL have port valid_i, input, 1, request present on addr_i/data_i/rw_i/id_i.
REQ-010 SHALL have port id_i, input, 4, requester tag.
REQ-011 SHALL have port stall_o, output, 1, queue cannot accept a request this cycle.
REQ-012 SHALL have port data_o, output, 256, fill line data.
REQ-013 SHALL have port valid_o, output, 1, one-cycle pulse qualifying data_o/id_o.
REQ-014 SHALL have port id_o, output, 4, tag of the read being answered.

Function
REQ-015 SHALL accept a request on a rising edge where valid_i=1 and stall_o=0; valid_i while stall_o=1 SHALL be ignored (the requester holds and retries).
REQ-016 SHALL index storage with addr_i[5+log2(MEM_LINES)-1:5]; addr_i[4:0] and upper bits ignored.
REQ-017 SHALL drive stall_o = 1 exactly when the queue holds QDEPTH entries; a pop and attempted push in the same full cycle SHALL not accept the push.
REQ-018 SHALL serve queued requests strictly in acceptance order, one at a time, via FSM IDLE -> BUSY -> RESP -> (BUSY if queue non-empty, else IDLE).
REQ-019 IDLE: on a non-empty queue, pop head, load latency counter, go to BUSY.
REQ-020 BUSY: decrement counter each cycle; at terminal count go to RESP.
REQ-021 RESP: read -> valid_o=1 for exactly one cycle with data_o = stored line, id_o = request tag; write -> store data_i line, valid_o stays 0 (posted writes, no acknowledgement).
REQ-022 With server idle and queue empty, a read accepted at edge T SHALL produce valid_o high in the cycle following edge T+LATENCY.
REQ-023 Each queued request SHALL occupy the server exactly LATENCY cycles; responses to back-to-back reads SHALL be spaced exactly LATENCY cycles apart.
REQ-024 A read queued behind a write to the same line SHALL return the written data (in-order guarantees read-after-write).
REQ-025 data_o and id_o SHALL hold their last value when valid_o=0.

Reset
REQ-026 Asserting reset SHALL immediately force: stall_o=0, valid_o=0, data_o=0, id_o=0, FSM=IDLE, counter=0, queue empty, all storage lines zero.
REQ-027 Reset asserted mid-service SHALL discard the in-flight and queued requests with no response emitted; first acceptance is the first edge after deassertion.

Structure
REQ-028 SHALL place line width (256), tag width (4), address width (32) and FSM state encoding in the shared cache package.
REQ-029 SHALL implement the request queue as a sub-module req_fifo (push/pop/full/empty, registered storage).

Verification
REQ-030 Reset then read addr 97 id 2 at T -> valid_o pulse at T+8+1 cycle, id_o=2, data_o=0.
REQ-031 Write addr 97 line 0x...08 id 6, then read addr 101 id 7 -> single valid_o, id_o=7, data_o=0x...08; no pulse for id 6.
REQ-032 Five requests back to back, server busy -> stall_o rises after fourth acceptance, fifth held until stall_o falls, responses in order at 8-cycle spacing.
REQ-033 Reads addr 65733 (id 3) and 197 (id 4) alias to line 6 -> both return same line content.
REQ-034 Reset pulsed 3 cycles after accepting read id 9 -> no valid_o for id 9, stall_o=0, next read after release answers normally.
